to_lower_stream: RTL and testbench

- Streaming ASCII lower-case converter; the inverse direction of the existing combinational toUpper block.
- Accepts one byte per cycle on a valid/ready input and maps 'A'..'Z' (65..90) to 'a'..'z' (97..122). All other bytes pass through unchanged.
- Results go through a 2-entry output buffer, so upstream is decoupled from downstream backpressure.
- Keeps saturating statistics counters for bytes accepted and bytes converted.

---
 rtl/ascii_pkg.sv | 27 ++
 rtl/ascii_lower_map.sv | 26 ++
 rtl/to_lower_stream.sv | 133 +++++++++++++
 tb/tb_to_lower_stream.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// ASCII helpers shared by the case-conversion blocks.
package ascii_pkg;

    typedef logic [7:0] ascii_t;

    localparam ascii_t ASCII_UPPER_A  = 8'd65;
    localparam ascii_t ASCII_UPPER_Z  = 8'd90;
    localparam ascii_t ASCII_LOWER_A  = 8'd97;
    localparam ascii_t ASCII_LOWER_Z  = 8'd122;
    localparam ascii_t ASCII_CASE_BIT = 8'h20;

    // Occupancy of the 2-entry output buffer; the only control state in the stream block.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    function automatic logic ascii_is_upper(ascii_t c);
        return (c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z);
    endfunction

    function automatic logic ascii_is_lower(ascii_t c);
        return (c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z);
    endfunction

endpackage

// File: rtl/ascii_lower_map.sv
// Combinational byte mapper: 'A'..'Z' become 'a'..'z', everything else passes through.
module ascii_lower_map
    import ascii_pkg::*;
(
    input  ascii_t char_i,
    output ascii_t char_o,
    output logic   is_upper_o
);

    logic is_upper;

    // Setting the case bit is enough because upper and lower letters differ only in bit 5.
    always_comb begin
        is_upper   = ascii_is_upper(char_i);
        char_o     = is_upper ? (char_i | ASCII_CASE_BIT) : char_i;
        is_upper_o = is_upper;
    end

    // A converted letter must land in the lower-case range.
    always_comb begin
        if (is_upper) begin
            assert (ascii_is_lower(char_o));
        end
    end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming lower-case converter with a 2-entry registered output buffer and
// saturating accepted/converted byte counters.
module to_lower_stream
    import ascii_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  char_count,
    output logic [CNT_W-1:0]  conv_count
);

    // Reject illegal parameterisations at elaboration time.
    if (DATA_W != 8) begin : g_bad_data_w
        $error("to_lower_stream: DATA_W must be 8");
    end
    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("to_lower_stream: CNT_W must be at least 2");
    end

    localparam logic [CNT_W-1:0] CntMax = '1;

    occ_e               occ_q, occ_d;
    ascii_t             head_q, head_d;
    ascii_t             tail_q, tail_d;
    logic [CNT_W-1:0]   char_cnt_q, char_cnt_d;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;

    ascii_t             mapped;
    logic               mapped_upper;
    logic               push;
    logic               pop;

    ascii_lower_map u_map (
        .char_i     (in_data),
        .char_o     (mapped),
        .is_upper_o (mapped_upper)
    );

    // Handshake flags come from registered occupancy only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (occ_q != StFull);
        out_valid = (occ_q != StEmpty);
        out_data  = head_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Buffer next state: head is always the oldest byte, tail only holds the second one.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            StEmpty: begin
                if (push) begin
                    head_d = mapped;
                    occ_d  = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    // Replace the departing head; occupancy unchanged, no bubble.
                    head_d = mapped;
                end else if (push) begin
                    tail_d = mapped;
                    occ_d  = StFull;
                end else if (pop) begin
                    occ_d  = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = StOne;
                end
            end
            default: begin
                occ_d = StEmpty;
            end
        endcase
    end

    // Counter next state: clear beats a same-cycle push; both saturate independently.
    always_comb begin
        char_cnt_d = char_cnt_q;
        conv_cnt_d = conv_cnt_q;
        if (cnt_clr) begin
            char_cnt_d = '0;
            conv_cnt_d = '0;
        end else if (push) begin
            if (char_cnt_q != CntMax) begin
                char_cnt_d = char_cnt_q + 1'b1;
            end
            if (mapped_upper && (conv_cnt_q != CntMax)) begin
                conv_cnt_d = conv_cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any buffered bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= StEmpty;
            head_q     <= '0;
            tail_q     <= '0;
            char_cnt_q <= '0;
            conv_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            char_cnt_q <= char_cnt_d;
            conv_cnt_q <= conv_cnt_d;
        end
    end

    // Counter outputs are plain register copies.
    always_comb begin
        char_count = char_cnt_q;
        conv_count = conv_cnt_q;
    end

endmodule

// File: tb/tb_to_lower_stream.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_to_lower_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       cnt_clr;
    logic [15:0] char_count;
    logic [15:0] conv_count;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic [3:0] s_char_count;
    logic [3:0] s_conv_count;

    to_lower_stream #(.CNT_W(16), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cnt_clr    (cnt_clr),
        .char_count (char_count),
        .conv_count (conv_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation checks.
    to_lower_stream #(.CNT_W(4), .DATA_W(8)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_data   (s_out_data),
        .cnt_clr    (cnt_clr),
        .char_count (s_char_count),
        .conv_count (s_conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: expected output bytes in order, and unbounded counts.
    int          exp_q[$];
    int unsigned m_char = 0;
    int unsigned m_conv = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lower_of(input int b);
        if (b >= 65 && b <= 90) return b + 32;
        return b;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned w);
        int unsigned mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_state();
        check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
            check_eq("small_out_data", 32'(s_out_data), 32'(exp_q[0]));
        end
        check_eq("char_count", 32'(char_count), sat(m_char, 16));
        check_eq("conv_count", 32'(conv_count), sat(m_conv, 16));
        check_eq("small_char_count", 32'(s_char_count), sat(m_char, 4));
        check_eq("small_conv_count", 32'(s_conv_count), sat(m_conv, 4));
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model, then clock.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        cnt_clr   = c;
        #2;
        check_state();
        do_push = v && (exp_q.size() != 2);
        do_pop  = r && (exp_q.size() != 0);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(lower_of(int'(d)));
        if (c) begin
            m_char = 0;
            m_conv = 0;
        end else if (do_push) begin
            m_char++;
            if (d >= 8'd65 && d <= 8'd90) m_conv++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_char = 0;
        m_conv = 0;
    endtask

    initial begin
        bit         pend_v;
        logic [7:0] pend_d;
        bit         v;
        bit         r;
        bit         c;
        logic [7:0] d;
        int         seq1[6];

        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        rst_n     = 1'b0;

        // Reset values while reset is held.
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_char_count", 32'(char_count), 32'd0);
        check_eq("rst_conv_count", 32'(conv_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mixed bytes including range boundaries, downstream always ready.
        seq1 = '{72, 97, 64, 91, 90, 200};
        foreach (seq1[i]) step(1'b1, 8'(seq1[i]), 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("seq1_char_count", 32'(char_count), 32'd6);
        check_eq("seq1_conv_count", 32'(conv_count), 32'd2);

        // Backpressure: fill to two, third byte held until space frees.
        step(1'b1, 8'd65, 1'b0, 1'b0);
        step(1'b1, 8'd66, 1'b0, 1'b0);
        step(1'b1, 8'd67, 1'b0, 1'b0);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'd67, 1'b1, 1'b0);
        step(1'b1, 8'd67, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Simultaneous push and pop at one entry keeps out_valid high.
        step(1'b1, 8'd69, 1'b0, 1'b0);
        step(1'b1, 8'd70, 1'b1, 1'b0);
        check_eq("pp_out_valid", 32'(out_valid), 32'd1);
        check_eq("pp_head", 32'(out_data), 32'd102);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Saturation on the narrow counters, then clear racing a push.
        for (int i = 0; i < 20; i++) step(1'b1, 8'd65, 1'b1, 1'b0);
        check_eq("sat_char", 32'(s_char_count), 32'd15);
        check_eq("sat_conv", 32'(s_conv_count), 32'd15);
        step(1'b1, 8'd66, 1'b1, 1'b1);
        check_eq("clr_char", 32'(char_count), 32'd0);
        check_eq("clr_conv", 32'(conv_count), 32'd0);
        check_eq("clr_byte_kept", 32'(out_data), 32'd98);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream drops buffered bytes.
        step(1'b1, 8'd72, 1'b0, 1'b0);
        step(1'b1, 8'd73, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_char", 32'(char_count), 32'd0);
        check_eq("arst_conv", 32'(conv_count), 32'd0);
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1, 1'b0);

        // Random traffic; a stalled byte is held until accepted.
        pend_v = 1'b0;
        pend_d = 8'd0;
        for (int i = 0; i < 400; i++) begin
            if (pend_v) begin
                v = 1'b1;
                d = pend_d;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 255));
                else d = 8'($urandom_range(60, 95));
            end
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 49) == 0);
            pend_v = v && (exp_q.size() == 2);
            pend_d = d;
            step(v, d, r, c);
        end
        // Drain.
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
